cart_mem_responder: RTL and testbench

CART_MEM_RESPONDER -- requirements
Module: cart_mem_responder

---
 rtl/cart_mem_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_cart_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_responder.sv
// cart_mem_responder: serves cartridge ROM strobes from a one-word buffer
// and forwards misses and writes to a req/ack word-wide memory backend.
// Ports: mclk/rst_n (async active-low); rom_* mapper side (byte address,
//   write data, active-low ce/oe/we, rom_word 16/8-bit select, rom_q read
//   data); mem_* backend side (word address, write data, byte enables,
//   req/we qualifiers, read data, one-cycle ack); busy while work is queued.
// Option: define CART_MEM_PREFETCH_EN to prefetch word tag+1 into a second
//   buffer after each demand read.
module cart_mem_responder #(
    parameter int ADDR_W = 24
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_d,
    input  logic              rom_ce_n,
    input  logic              rom_oe_n,
    input  logic              rom_we_n,
    input  logic              rom_word,
    output logic [15:0]       rom_q,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_dout,
    output logic [1:0]        mem_be,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              busy
);
    localparam int WA = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t        state_q, state_d;
    logic [WA-1:0] addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic [1:0]    be_q, be_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   buf_q, buf_d;
    logic [WA-1:0] tag_q, tag_d;
    logic          bv_q, bv_d;
    logic          pv_q, pv_d;
    logic          pwe_q, pwe_d;
    logic [WA-1:0] paddr_q, paddr_d;
    logic [15:0]   pdout_q, pdout_d;
    logic [1:0]    pbe_q, pbe_d;
    logic          we_n_q;

`ifdef CART_MEM_PREFETCH_EN
    localparam logic [WA-1:0] WONE = {{(WA-1){1'b0}}, 1'b1};
    logic [15:0]   pfb_q, pfb_d;
    logic [WA-1:0] pft_q, pft_d;
    logic          pfv_q, pfv_d;
    logic          pfc_q, pfc_d;
    logic          do_pf;
    logic [WA-1:0] pf_addr;
`endif

    logic [WA-1:0] waddr;
    logic          rd_act, wr_trig, rd_trig, hit, covered, pf_hit;
    logic          nt_v;
    logic [1:0]    nt_be;
    logic [15:0]   nt_dout;
    logic [7:0]    bsel;
    logic          do_nt, do_pend, keep_nt;

    assign waddr   = rom_addr[ADDR_W-1:1];
    assign rd_act  = !rom_ce_n && !rom_oe_n;
    assign wr_trig = we_n_q && !rom_we_n && !rom_ce_n;
    assign hit     = bv_q && (tag_q == waddr);
    // A word already in flight or queued as a read is not requested again.
    assign covered = (state_q == RD_WAIT && addr_q == waddr) ||
                     (pv_q && !pwe_q && paddr_q == waddr);
`ifdef CART_MEM_PREFETCH_EN
    assign pf_hit  = pfv_q && (pft_q == waddr);
`else
    assign pf_hit  = 1'b0;
`endif
    assign rd_trig = rd_act && !hit && !pf_hit && !covered;
    assign nt_v    = wr_trig || rd_trig;
    assign nt_be   = (wr_trig && !rom_word) ?
                     (rom_addr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign nt_dout = !wr_trig ? 16'h0000 :
                     rom_word ? rom_d : {2{rom_d[7:0]}};

    assign bsel     = rom_addr[0] ? buf_q[15:8] : buf_q[7:0];
    assign rom_q    = rom_word ? buf_q : {bsel, bsel};
    assign mem_addr = addr_q;
    assign mem_dout = dout_q;
    assign mem_be   = be_q;
    assign mem_req  = req_q;
    assign mem_we   = we_q;
    assign busy     = (state_q != IDLE) || pv_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        be_d    = be_q;
        req_d   = req_q;
        we_d    = we_q;
        buf_d   = buf_q;
        tag_d   = tag_q;
        bv_d    = bv_q;
        pv_d    = pv_q;
        pwe_d   = pwe_q;
        paddr_d = paddr_q;
        pdout_d = pdout_q;
        pbe_d   = pbe_q;
        do_nt   = 1'b0;
        do_pend = 1'b0;
        keep_nt = 1'b0;
`ifdef CART_MEM_PREFETCH_EN
        pfb_d   = pfb_q;
        pft_d   = pft_q;
        pfv_d   = pfv_q;
        pfc_d   = pfc_q;
        do_pf   = 1'b0;
        pf_addr = pft_q + WONE;
        // Promotion runs first so a prefetch ack this cycle is not lost.
        if (rd_act && pf_hit && !hit) begin
            buf_d = pfb_q;
            tag_d = pft_q;
            bv_d  = 1'b1;
            pfv_d = 1'b0;
            if (state_q == IDLE && !nt_v) begin
                do_pf = 1'b1;
            end
        end
`endif
        unique case (state_q)
            IDLE: begin
                do_nt = nt_v;
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack) begin
                    if (state_q == RD_WAIT) begin
`ifdef CART_MEM_PREFETCH_EN
                        if (pfc_q) begin
                            pfb_d = mem_din;
                            pft_d = addr_q;
                            pfv_d = 1'b1;
                        end else begin
                            buf_d = mem_din;
                            tag_d = addr_q;
                            bv_d  = 1'b1;
                        end
`else
                        buf_d = mem_din;
                        tag_d = addr_q;
                        bv_d  = 1'b1;
`endif
                    end
                    if (pv_q) begin
                        do_pend = 1'b1;
                        keep_nt = nt_v;
                    end else if (nt_v) begin
                        do_nt = 1'b1;
`ifdef CART_MEM_PREFETCH_EN
                    end else if (state_q == RD_WAIT && !pfc_q) begin
                        do_pf   = 1'b1;
                        pf_addr = addr_q + WONE;
`endif
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end else if (nt_v && !(pv_q && pwe_q)) begin
                    // A queued write is never displaced.
                    keep_nt = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_pend) begin
            pv_d = 1'b0;
        end
        if (keep_nt) begin
            pv_d    = 1'b1;
            pwe_d   = wr_trig;
            paddr_d = waddr;
            pdout_d = nt_dout;
            pbe_d   = nt_be;
        end

        if (do_nt) begin
            state_d = wr_trig ? WR_WAIT : RD_WAIT;
            addr_d  = waddr;
            dout_d  = nt_dout;
            be_d    = nt_be;
            req_d   = 1'b1;
            we_d    = wr_trig;
        end
        if (do_pend) begin
            state_d = pwe_q ? WR_WAIT : RD_WAIT;
            addr_d  = paddr_q;
            dout_d  = pdout_q;
            be_d    = pbe_q;
            req_d   = 1'b1;
            we_d    = pwe_q;
        end
`ifdef CART_MEM_PREFETCH_EN
        pfc_d = do_pf ? 1'b1 : ((do_nt || do_pend) ? 1'b0 : pfc_d);
        if (do_pf) begin
            state_d = RD_WAIT;
            addr_d  = pf_addr;
            dout_d  = 16'h0000;
            be_d    = 2'b11;
            req_d   = 1'b1;
            we_d    = 1'b0;
        end
        if (wr_trig && pfv_d && pft_d == waddr) begin
            if (nt_be[0]) pfb_d[7:0]  = nt_dout[7:0];
            if (nt_be[1]) pfb_d[15:8] = nt_dout[15:8];
        end
`endif
        // Merge against the post-completion buffer so a same-cycle
        // read fill cannot hide an accepted write.
        if (wr_trig && bv_d && tag_d == waddr) begin
            if (nt_be[0]) buf_d[7:0]  = nt_dout[7:0];
            if (nt_be[1]) buf_d[15:8] = nt_dout[15:8];
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            be_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            buf_q   <= '0;
            tag_q   <= '0;
            bv_q    <= 1'b0;
            pv_q    <= 1'b0;
            pwe_q   <= 1'b0;
            paddr_q <= '0;
            pdout_q <= '0;
            pbe_q   <= '0;
            we_n_q  <= 1'b1;
`ifdef CART_MEM_PREFETCH_EN
            pfb_q   <= '0;
            pft_q   <= '0;
            pfv_q   <= 1'b0;
            pfc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            be_q    <= be_d;
            req_q   <= req_d;
            we_q    <= we_d;
            buf_q   <= buf_d;
            tag_q   <= tag_d;
            bv_q    <= bv_d;
            pv_q    <= pv_d;
            pwe_q   <= pwe_d;
            paddr_q <= paddr_d;
            pdout_q <= pdout_d;
            pbe_q   <= pbe_d;
            we_n_q  <= rom_we_n;
`ifdef CART_MEM_PREFETCH_EN
            pfb_q   <= pfb_d;
            pft_q   <= pft_d;
            pfv_q   <= pfv_d;
            pfc_q   <= pfc_d;
`endif
        end
    end

endmodule

// File: tb/tb_cart_mem_responder.sv
// tb_cart_mem_responder: directed checks of cart_mem_responder.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_cart_mem_responder;
    localparam int ADDR_W = 24;

    logic              mclk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_d;
    logic              rom_ce_n, rom_oe_n, rom_we_n, rom_word;
    logic [15:0]       rom_q;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_dout;
    logic [1:0]        mem_be;
    logic              mem_req, mem_we;
    logic [15:0]       mem_din;
    logic              mem_ack;
    logic              busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   issues  = 0;
    int   base    = 0;
    logic rq_prev = 1'b0;
    logic ak_prev = 1'b0;

    always #5 mclk = ~mclk;

    cart_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .rom_addr (rom_addr),
        .rom_d    (rom_d),
        .rom_ce_n (rom_ce_n),
        .rom_oe_n (rom_oe_n),
        .rom_we_n (rom_we_n),
        .rom_word (rom_word),
        .rom_q    (rom_q),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_be   (mem_be),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_ack  (mem_ack),
        .busy     (busy)
    );

    // A new backend transaction starts when req rises or stays high
    // straight after an ack.
    always @(negedge mclk) begin
        if (mem_req && (!rq_prev || ak_prev)) issues <= issues + 1;
        rq_prev <= mem_req;
        ak_prev <= mem_ack;
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; rom_addr = '0; rom_d = '0; rom_word = 1'b1;
        rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_we_n = 1'b1;
        mem_din = '0; mem_ack = 1'b0;
        #2;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_dout", 32'(mem_dout), 0);
        chk("rst_romq", 32'(rom_q), 0);
        chk("rst_busy", 32'(busy), 0);
        tick(); tick();

        // stray ack right after reset release
        rst_n = 1'b1; mem_ack = 1'b1; mem_din = 16'h1234;
        tick(); mem_ack = 1'b0;
        tick();
        chk("stray_req", 32'(mem_req), 0);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_romq", 32'(rom_q), 0);

        // read miss 0x000100
        rom_addr = 24'h000100; rom_word = 1'b1;
        rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        tick();
        chk("miss_req", 32'(mem_req), 1);
        chk("miss_addr", 32'(mem_addr), 32'h80);
        chk("miss_we", 32'(mem_we), 0);
        chk("miss_busy", 32'(busy), 1);
        tick(); tick(); tick();
        chk("miss_hold", 32'(mem_req), 1);
        mem_din = 16'hBEEF; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("miss_reqdrop", 32'(mem_req), 0);
        tick();
        chk("miss_romq", 32'(rom_q), 32'hBEEF);
        chk("miss_issues", 32'(issues), 1);
        chk("miss_idle", 32'(busy), 0);

        // byte read hit
        rom_addr = 24'h000101; rom_word = 1'b0;
        #1;
        chk("hit_romq", 32'(rom_q), 32'hBEBE);
        tick(); tick();
        chk("hit_noreq", 32'(mem_req), 0);
        chk("hit_issues", 32'(issues), 1);

        // byte write
        rom_oe_n = 1'b1;
        tick();
        rom_addr = 24'h000100; rom_word = 1'b0; rom_d = 16'h0012;
        rom_we_n = 1'b0;
        tick();
        chk("wr_req", 32'(mem_req), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_be", 32'(mem_be), 32'h1);
        chk("wr_dout", 32'(mem_dout), 32'h1212);
        chk("wr_addr", 32'(mem_addr), 32'h80);
        rom_word = 1'b1;
        #1;
        chk("wr_buf", 32'(rom_q), 32'hBE12);

        // read queued behind the write
        rom_we_n = 1'b1; rom_addr = 24'h000200; rom_oe_n = 1'b0;
        tick();
        chk("q_busy", 32'(busy), 1);
        tick();
        chk("q_addr_hold", 32'(mem_addr), 32'h80);
        chk("q_we_hold", 32'(mem_we), 1);
        chk("q_be_hold", 32'(mem_be), 32'h1);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("q_issue_req", 32'(mem_req), 1);
        chk("q_issue_addr", 32'(mem_addr), 32'h100);
        chk("q_issue_we", 32'(mem_we), 0);
        chk("q_issue_be", 32'(mem_be), 32'h3);
        tick();
        chk("q_issues", 32'(issues), 3);

        // reset in RD_WAIT
        rom_oe_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req", 32'(mem_req), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_romq", 32'(rom_q), 0);
        tick();
        rst_n = 1'b1; mem_ack = 1'b1; mem_din = 16'hDEAD;
        tick(); mem_ack = 1'b0;
        tick();
        chk("rr_late_req", 32'(mem_req), 0);
        chk("rr_late_busy", 32'(busy), 0);
        chk("rr_late_romq", 32'(rom_q), 0);
        chk("rr_issues", 32'(issues), 3);
        rom_oe_n = 1'b0;
        tick();
        chk("rr_remiss_req", 32'(mem_req), 1);
        chk("rr_remiss_addr", 32'(mem_addr), 32'h100);
        mem_din = 16'h5A5A; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        tick();
        chk("rr_romq", 32'(rom_q), 32'h5A5A);

        // newer read replaces a queued read
        rom_addr = 24'h000400;
        tick();
        chk("ow_first", 32'(mem_addr), 32'h200);
        rom_addr = 24'h000600;
        tick();
        rom_addr = 24'h000800;
        tick();
        chk("ow_hold", 32'(mem_addr), 32'h200);
        mem_din = 16'h1111; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("ow_req", 32'(mem_req), 1);
        chk("ow_addr", 32'(mem_addr), 32'h400);
        mem_din = 16'h7777; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        tick();
        chk("ow_romq", 32'(rom_q), 32'h7777);
        chk("ow_idle", 32'(busy), 0);
        chk("ow_issues", 32'(issues), 6);

        // high byte write at the top of the address space
        rom_oe_n = 1'b1;
        tick();
        rom_addr = 24'hFFFFFF; rom_word = 1'b0; rom_d = 16'h00AB;
        rom_we_n = 1'b0;
        tick();
        chk("top_addr", 32'(mem_addr), 32'h7FFFFF);
        chk("top_be", 32'(mem_be), 32'h2);
        chk("top_dout", 32'(mem_dout), 32'hABAB);
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; rom_we_n = 1'b1;
        tick();
        chk("top_idle", 32'(busy), 0);

        // write and read trigger together: write goes first
        rom_addr = 24'h000A00; rom_word = 1'b1; rom_d = 16'hCAFE;
        rom_oe_n = 1'b0; rom_we_n = 1'b0;
        tick();
        chk("both_we", 32'(mem_we), 1);
        chk("both_addr", 32'(mem_addr), 32'h500);
        chk("both_dout", 32'(mem_dout), 32'hCAFE);
        chk("both_be", 32'(mem_be), 32'h3);
        rom_we_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("both_rd_req", 32'(mem_req), 1);
        chk("both_rd_we", 32'(mem_we), 0);
        mem_din = 16'hF00D; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        tick();
        chk("both_romq", 32'(rom_q), 32'hF00D);

`ifdef CART_MEM_PREFETCH_EN
        rom_oe_n = 1'b1; rom_ce_n = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rom_addr = 24'h000000; rom_word = 1'b1;
        rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        tick();
        chk("pf_d0", 32'(mem_addr), 0);
        mem_din = 16'h1111; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        chk("pf_req", 32'(mem_req), 1);
        chk("pf_addr1", 32'(mem_addr), 1);
        mem_din = 16'h2222; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        base = issues;
        rom_addr = 24'h000002;
        tick();
        chk("pf_romq", 32'(rom_q), 32'h2222);
        chk("pf_next_req", 32'(mem_req), 1);
        chk("pf_next_addr", 32'(mem_addr), 2);
        tick();
        chk("pf_issues", 32'(issues), 32'(base + 1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
